// File: rtl/bram_wb_banked.sv
// Wishbone slave in front of NUM_BANKS dual-port RAM banks. Port A of every bank is
// shared behind the slave; port B of each bank is an independent read-first fabric port.
module bram_wb_banked #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_BANKS   = 4,
    parameter int SLEEP_COUNT = 4
) (
    input  logic                             wbs_clk_i,
    input  logic                             wbs_rst_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_we_i,
    input  logic [DATA_WIDTH/8-1:0]          wbs_sel_i,
    input  logic [31:0]                      wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]            wbs_dat_i,
    output logic [DATA_WIDTH-1:0]            wbs_dat_o,
    output logic                             wbs_ack_o,
    output logic                             wbs_err_o,
    input  logic [NUM_BANKS-1:0]             fabric_we,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  fabric_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  fabric_data_in,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  fabric_data_out
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int NB_BYTES  = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int BANK_LSB  = ADDR_WIDTH + 2;
    localparam logic [7:0] SLEEP_INIT = 8'(SLEEP_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [ADDR_WIDTH-1:0]   word_q;
    logic [BANK_BITS-1:0]    bank_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [NB_BYTES-1:0]     sel_q;
    logic                    we_q;

    logic                    req_s;
    logic                    latch_s;
    logic                    rd_load_s;
    logic                    bank_ok_s;
    logic                    a_we_s;
    logic                    a_re_s;
    logic [DATA_WIDTH-1:0]   rd_mux_s;
    logic                    unused_adr_s;

    logic [DATA_WIDTH-1:0]   a_rd_q   [NUM_BANKS];
    logic [DATA_WIDTH-1:0]   fab_rd_q [NUM_BANKS];

    assign unused_adr_s = ^{wbs_adr_i[31:BANK_LSB+BANK_BITS], wbs_adr_i[1:0]};

    // While ack/err is still showing, the master has not yet seen it and keeps
    // cyc/stb up; refusing new requests then prevents re-latching the same one.
    assign req_s     = wbs_cyc_i && wbs_stb_i && !ack_q && !err_q;
    assign bank_ok_s = (32'(bank_q) < 32'(NUM_BANKS));
    assign a_we_s    = (state_q == ACCESS) && wbs_cyc_i && !wbs_rst_i && we_q && bank_ok_s;
    assign a_re_s    = (state_q == ACCESS) && !we_q && bank_ok_s;

    // Next-state and response decode for the Wishbone transaction FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_s   = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rd_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    latch_s = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (SLEEP_INIT != 8'd0) begin
                    state_d = WAIT;
                    cnt_d   = SLEEP_INIT;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd1) begin
                    state_d = RESP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (wbs_cyc_i) begin
                    ack_d     = bank_ok_s;
                    err_d     = !bank_ok_s;
                    rd_load_s = bank_ok_s && !we_q;
                end else begin
                    ack_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // FSM state, wait counter and registered ack/err.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            word_q <= '0;
            bank_q <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
        end else if (latch_s) begin
            word_q <= wbs_adr_i[BANK_LSB-1:2];
            bank_q <= wbs_adr_i[BANK_LSB+BANK_BITS-1:BANK_LSB];
            dat_q  <= wbs_dat_i;
            sel_q  <= wbs_sel_i;
            we_q   <= wbs_we_i;
        end
    end

    // Select the port-A read register of the addressed bank.
    always_comb begin
        rd_mux_s = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            rd_mux_s = (bank_q == BANK_BITS'(k)) ? a_rd_q[k] : rd_mux_s;
        end
    end

    // Wishbone read data, updated only by successful reads.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            rdata_q <= '0;
        end else if (rd_load_s) begin
            rdata_q <= rd_mux_s;
        end
    end

    assign wbs_dat_o = rdata_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        localparam logic [BANK_BITS-1:0] BANK_ID = BANK_BITS'(k);

        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [ADDR_WIDTH-1:0] f_addr_s;
        logic [DATA_WIDTH-1:0] f_din_s;

        assign f_addr_s = fabric_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign f_din_s  = fabric_data_in[k*DATA_WIDTH +: DATA_WIDTH];

        // RAM array; the fabric write is issued last so it wins a same-word collision.
        always_ff @(posedge wbs_clk_i) begin
            if (a_we_s && (bank_q == BANK_ID)) begin
                for (int b = 0; b < NB_BYTES; b++) begin
                    if (sel_q[b]) begin
                        mem_q[word_q][8*b +: 8] <= dat_q[8*b +: 8];
                    end
                end
            end
            if (fabric_we[k]) begin
                mem_q[f_addr_s] <= f_din_s;
            end
        end

        // Read-first output registers for both ports.
        always_ff @(posedge wbs_clk_i) begin
            if (wbs_rst_i) begin
                fab_rd_q[k] <= '0;
                a_rd_q[k]   <= '0;
            end else begin
                fab_rd_q[k] <= mem_q[f_addr_s];
                if (a_re_s && (bank_q == BANK_ID)) begin
                    a_rd_q[k] <= mem_q[word_q];
                end
            end
        end

        assign fabric_data_out[k*DATA_WIDTH +: DATA_WIDTH] = fab_rd_q[k];
    end

endmodule

// File: tb/tb_bram_wb_banked.sv
// Randomised self-checking bench for bram_wb_banked: a 4-bank/SLEEP=4 instance and a
// 3-bank/SLEEP=0 instance checked against a word-array model of the RAM contents.
module tb_bram_wb_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic cyc0, stb0, we0, ack0, err0;
    logic [3:0] sel0, fwe0;
    logic [31:0] adr0, dati0, dato0, faddr0;
    logic [127:0] fdin0, fdout0;

    logic cyc1, stb1, we1, ack1, err1;
    logic [3:0] sel1;
    logic [2:0] fwe1;
    logic [31:0] adr1, dati1, dato1;
    logic [23:0] faddr1;
    logic [95:0] fdin1, fdout1;

    logic [31:0] mdl [4][256];
    int checks = 0;
    int errors = 0;

    bram_wb_banked #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_BANKS(4), .SLEEP_COUNT(4)) dut0 (
        .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb0), .wbs_we_i(we0),
        .wbs_sel_i(sel0), .wbs_adr_i(adr0), .wbs_dat_i(dati0), .wbs_dat_o(dato0),
        .wbs_ack_o(ack0), .wbs_err_o(err0), .fabric_we(fwe0), .fabric_addr(faddr0),
        .fabric_data_in(fdin0), .fabric_data_out(fdout0));

    bram_wb_banked #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_BANKS(3), .SLEEP_COUNT(0)) dut1 (
        .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb1), .wbs_we_i(we1),
        .wbs_sel_i(sel1), .wbs_adr_i(adr1), .wbs_dat_i(dati1), .wbs_dat_o(dato1),
        .wbs_ack_o(ack1), .wbs_err_o(err1), .fabric_we(fwe1), .fabric_addr(faddr1),
        .fabric_data_in(fdin1), .fabric_data_out(fdout1));

    task automatic wb_drive(input int d, input bit c, input bit we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        if (d == 0) begin
            cyc0 = c; stb0 = c; we0 = we; adr0 = adr; dati0 = dat; sel0 = sel;
        end else begin
            cyc1 = c; stb1 = c; we1 = we; adr1 = adr; dati1 = dat; sel1 = sel;
        end
    endtask

    // lat = number of edges after the accepting edge until ack/err is seen (bounded).
    task automatic wb_wait(input int d, input int n0, output logic [31:0] rdata, output int lat,
                           output bit got_ack, output bit got_err, output bit pulse);
        lat = -1; got_ack = 1'b0; got_err = 1'b0; rdata = 32'd0; pulse = 1'b0;
        for (int n = n0; n < 60; n++) begin
            @(negedge clk);
            if ((d == 0 ? (ack0 | err0) : (ack1 | err1)) === 1'b1) begin
                lat = n;
                got_ack = (d == 0) ? ack0 : ack1;
                got_err = (d == 0) ? err0 : err1;
                rdata   = (d == 0) ? dato0 : dato1;
                break;
            end
        end
        wb_drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        pulse = (d == 0) ? !(ack0 | err0) : !(ack1 | err1);
    endtask

    task automatic wb_xact(input int d, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata, output int lat,
                           output bit got_ack, output bit got_err, output bit pulse);
        @(negedge clk);
        wb_drive(d, 1'b1, we, adr, dat, sel);
        wb_wait(d, 0, rdata, lat, got_ack, got_err, pulse);
    endtask

    task automatic mdl_wr(input int b, input int w, input logic [31:0] dat, input logic [3:0] sel);
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) mdl[b][w][8*i +: 8] = dat[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] mk_adr(input int b, input int w);
        return (32'(b) << 10) | (32'(w) << 2);
    endfunction

    task automatic test_reset();
        checks++; if ({ack0, err0, ack1, err1} !== 4'b0000) begin errors++; $display("FAIL reset_ack_err: got %b expected 0000", {ack0, err0, ack1, err1}); end
        checks++; if (dato0 !== 32'd0 || dato1 !== 32'd0) begin errors++; $display("FAIL reset_dat_o: got %h/%h expected 0", dato0, dato1); end
        checks++; if (fdout0 !== 128'd0 || fdout1 !== 96'd0) begin errors++; $display("FAIL reset_fabric_out: got %h expected 0", fdout0); end
    endtask

    task automatic fill_mem();
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            fwe0 = 4'hF;
            for (int k = 0; k < 4; k++) begin
                faddr0[k*8 +: 8] = 8'(a);
                fdin0[k*32 +: 32] = $urandom;
                mdl[k][a] = fdin0[k*32 +: 32];
            end
        end
        @(negedge clk);
        fwe0 = 4'h0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lat; bit ga, ge, pl;
        wb_xact(0, 1'b1, 32'h0000_0504, 32'hDEAD_BEEF, 4'hF, rd, lat, ga, ge, pl);
        mdl_wr(1, 8'h41, 32'hDEAD_BEEF, 4'hF);
        checks++; if (lat !== 6 || ga !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL basic_wr_ack: lat %0d ack %b err %b expected 6 1 0", lat, ga, ge); end
        checks++; if (pl !== 1'b1) begin errors++; $display("FAIL basic_wr_pulse: ack still high after one cycle"); end
        wb_xact(0, 1'b0, 32'h0000_0504, 32'd0, 4'h0, rd, lat, ga, ge, pl);
        checks++; if (lat !== 6 || ga !== 1'b1) begin errors++; $display("FAIL basic_rd_ack: lat %0d ack %b expected 6 1", lat, ga); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
        faddr0[15:8] = 8'h41;
        @(negedge clk);
        checks++; if (fdout0[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_fabric_rd: got %h expected deadbeef", fdout0[63:32]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int lat; bit ga, ge, pl;
        wb_xact(0, 1'b1, mk_adr(2, 7), 32'h1122_3344, 4'hF, rd, lat, ga, ge, pl);
        wb_xact(0, 1'b1, mk_adr(2, 7) | 32'hFFFF_F003, 32'hAABB_CCDD, 4'h6, rd, lat, ga, ge, pl);
        wb_xact(0, 1'b0, mk_adr(2, 7), 32'd0, 4'h1, rd, lat, ga, ge, pl);
        mdl[2][7] = 32'h11BB_CC44;
        checks++; if (rd !== 32'h11BB_CC44) begin errors++; $display("FAIL byte_lane_merge: got %h expected 11bbcc44", rd); end
        wb_xact(0, 1'b1, mk_adr(2, 7), 32'h0, 4'h0, rd, lat, ga, ge, pl);
        checks++; if (lat !== 6 || ga !== 1'b1) begin errors++; $display("FAIL sel0_ack: lat %0d ack %b expected 6 1", lat, ga); end
        wb_xact(0, 1'b0, mk_adr(2, 7), 32'd0, 4'h0, rd, lat, ga, ge, pl);
        checks++; if (rd !== 32'h11BB_CC44) begin errors++; $display("FAIL sel0_unchanged: got %h expected 11bbcc44", rd); end
    endtask

    task automatic test_random_wb();
        logic [31:0] rd, dat, adr, exp_rd; int lat, b, w; bit ga, ge, pl, we; logic [3:0] sel;
        for (int t = 0; t < 24; t++) begin
            b = $urandom_range(0, 3); w = $urandom_range(0, 255); we = 1'($urandom_range(0, 1));
            sel = 4'($urandom); dat = $urandom;
            adr = ($urandom << 12) | mk_adr(b, w) | 32'($urandom_range(0, 3));
            exp_rd = mdl[b][w];
            wb_xact(0, we, adr, dat, sel, rd, lat, ga, ge, pl);
            if (we) mdl_wr(b, w, dat, sel);
            checks++; if (lat !== 6 || ga !== 1'b1 || ge !== 1'b0 || pl !== 1'b1) begin errors++; $display("FAIL rand_resp[%0d]: lat %0d ack %b err %b pulse %b expected 6 1 0 1", t, lat, ga, ge, pl); end
            if (!we) begin
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rd[%0d]: adr %h got %h expected %h", t, adr, rd, exp_rd); end
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; int lat; bit ga, ge, pl;
        wb_xact(1, 1'b1, 32'h0000_0000, 32'h1357_9BDF, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (lat !== 2 || ga !== 1'b1) begin errors++; $display("FAIL s0_wr_ack: lat %0d ack %b expected 2 1", lat, ga); end
        wb_xact(1, 1'b0, 32'h0000_0000, 32'd0, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL s0_rd_data: got %h expected 13579bdf", rd); end
        wb_xact(1, 1'b1, 32'h0000_0C00, 32'hFFFF_FFFF, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (lat !== 2 || ge !== 1'b1 || ga !== 1'b0 || pl !== 1'b1) begin errors++; $display("FAIL err_wr: lat %0d err %b ack %b pulse %b expected 2 1 0 1", lat, ge, ga, pl); end
        wb_xact(1, 1'b0, 32'h0000_0C00, 32'd0, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (lat !== 2 || ge !== 1'b1 || ga !== 1'b0) begin errors++; $display("FAIL err_rd: lat %0d err %b ack %b expected 2 1 0", lat, ge, ga); end
        checks++; if (dato1 !== 32'h1357_9BDF) begin errors++; $display("FAIL err_dat_hold: got %h expected 13579bdf", dato1); end
        wb_xact(1, 1'b0, 32'h0000_0000, 32'd0, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL err_ram_intact: got %h expected 13579bdf", rd); end
    endtask

    task automatic test_collision();
        logic [31:0] rd; int lat; bit ga, ge, pl;
        @(negedge clk);
        wb_drive(0, 1'b1, 1'b1, mk_adr(0, 5), 32'h1, 4'hF);
        @(negedge clk);
        fwe0 = 4'h1; faddr0[7:0] = 8'd5; fdin0[31:0] = 32'h2;
        @(negedge clk);
        fwe0 = 4'h0;
        wb_wait(0, 2, rd, lat, ga, ge, pl);
        mdl[0][5] = 32'h2;
        checks++; if (lat !== 6 || ga !== 1'b1) begin errors++; $display("FAIL collide_ack: lat %0d ack %b expected 6 1", lat, ga); end
        @(negedge clk);
        wb_drive(0, 1'b1, 1'b0, mk_adr(0, 5), 32'h0, 4'hF);
        @(negedge clk);
        fwe0 = 4'h1; fdin0[31:0] = 32'h3;
        @(negedge clk);
        fwe0 = 4'h0;
        wb_wait(0, 2, rd, lat, ga, ge, pl);
        checks++; if (rd !== mdl[0][5]) begin errors++; $display("FAIL collide_rd_old: got %h expected %h", rd, mdl[0][5]); end
        mdl[0][5] = 32'h3;
        wb_xact(0, 1'b0, mk_adr(0, 5), 32'd0, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (rd !== mdl[0][5]) begin errors++; $display("FAIL collide_rd_new: got %h expected %h", rd, mdl[0][5]); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat, seen; bit ga, ge, pl;
        @(negedge clk);
        wb_drive(0, 1'b1, 1'b0, mk_adr(3, 9), 32'd0, 4'hF);
        repeat (3) @(negedge clk);
        wb_drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(negedge clk);
        checks++; if (ack0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL abort_wait_resp: ack %b err %b expected 0 0", ack0, err0); end
        wb_drive(0, 1'b1, 1'b0, mk_adr(3, 9), 32'd0, 4'hF);
        wb_wait(0, 0, rd, lat, ga, ge, pl);
        checks++; if (lat !== 6 || rd !== mdl[3][9]) begin errors++; $display("FAIL abort_next_req: lat %0d data %h expected 6 %h", lat, rd, mdl[3][9]); end
        @(negedge clk);
        wb_drive(0, 1'b1, 1'b1, mk_adr(3, 9), ~mdl[3][9], 4'hF);
        @(negedge clk);
        wb_drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack0 === 1'b1 || err0 === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_access_resp: %0d response cycles expected 0", seen); end
        wb_xact(0, 1'b0, mk_adr(3, 9), 32'd0, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (rd !== mdl[3][9]) begin errors++; $display("FAIL abort_access_nowrite: got %h expected %h", rd, mdl[3][9]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; bit ga, ge, pl;
        @(negedge clk);
        wb_drive(0, 1'b1, 1'b1, mk_adr(2, 16), 32'h5A5A_1234, 4'hF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ack0, err0} !== 2'b00 || dato0 !== 32'd0 || fdout0 !== 128'd0) begin errors++; $display("FAIL mid_reset_outputs: ack %b err %b dat %h fab %h expected all 0", ack0, err0, dato0, fdout0); end
        rst = 1'b0;
        wb_drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        mdl[2][16] = 32'h5A5A_1234;
        wb_xact(0, 1'b0, mk_adr(2, 16), 32'd0, 4'hF, rd, lat, ga, ge, pl);
        checks++; if (rd !== 32'h5A5A_1234 || lat !== 6) begin errors++; $display("FAIL mid_reset_kept: got %h lat %0d expected 5a5a1234 6", rd, lat); end
        fwe0 = 4'h4; faddr0[23:16] = 8'h33; fdin0[95:64] = 32'h0000_CAFE;
        @(negedge clk);
        fwe0 = 4'h0;
        checks++; if (fdout0[95:64] !== mdl[2][8'h33]) begin errors++; $display("FAIL fabric_read_first: got %h expected %h", fdout0[95:64], mdl[2][8'h33]); end
        mdl[2][8'h33] = 32'h0000_CAFE;
        @(negedge clk);
        checks++; if (fdout0[95:64] !== 32'h0000_CAFE) begin errors++; $display("FAIL fabric_cafe: got %h expected 0000cafe", fdout0[95:64]); end
    endtask

    task automatic test_fabric_random();
        logic [31:0] exp_out [4];
        int a;
        for (int t = 0; t < 32; t++) begin
            for (int k = 0; k < 4; k++) begin
                a = $urandom_range(0, 255);
                fwe0[k] = 1'($urandom_range(0, 1));
                faddr0[k*8 +: 8] = 8'(a);
                fdin0[k*32 +: 32] = $urandom;
                exp_out[k] = mdl[k][a];
                if (fwe0[k]) mdl[k][a] = fdin0[k*32 +: 32];
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++; if (fdout0[k*32 +: 32] !== exp_out[k]) begin errors++; $display("FAIL fabric_rand[%0d][%0d]: got %h expected %h", t, k, fdout0[k*32 +: 32], exp_out[k]); end
            end
        end
        fwe0 = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        wb_drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        wb_drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        fwe0 = 4'h0; faddr0 = 32'd0; fdin0 = 128'd0;
        fwe1 = 3'd0; faddr1 = 24'd0; fdin1 = 96'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        fill_mem();
        test_basic();
        test_byte_lanes();
        test_random_wb();
        test_error();
        test_collision();
        test_abort();
        test_reset_mid();
        test_fabric_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
